// File: rtl/lsu_multicycle_if.sv
// rtl/lsu_multicycle_if.sv - word-memory request/acknowledge bus between the LSU and a wait-stated data memory
interface lsu_multicycle_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_multicycle.sv
// rtl/lsu_multicycle.sv - multi-cycle RV32 load/store unit; define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses
module lsu_multicycle #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [31:0]       rdata,
    lsu_multicycle_if.master  mem
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;
    localparam logic [7:0] TO_LAST      = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        split_q;
    logic [3:0]  strb_hi_q;
    logic [31:0] wdata_hi_q;
    logic [31:0] word0_q;
    logic [7:0]  cnt_q;

    logic        f3_illegal, misaligned, crosses;
    logic [3:0]  size_mask;
    logic [2:0]  size_bytes;
    logic [7:0]  strb_wide;
    logic [63:0] wdata_wide;

    logic        beat, timed_out, last_ack;
    logic [1:0]  resp_err;

    logic [63:0] load_pair, load_shr;
    logic [31:0] load_ext;

    // Decode the request presented with start: legality, alignment, lane masks over a two-word window
    always_comb begin
        size_mask  = 4'b0001;
        size_bytes = 3'd1;
        f3_illegal = 1'b0;
        case (funct3[1:0])
            2'b01:   begin size_mask = 4'b0011; size_bytes = 3'd2; end
            2'b10:   begin size_mask = 4'b1111; size_bytes = 3'd4; end
            default: ;
        endcase
        if (is_store)
            f3_illegal = funct3[2] || (funct3[1:0] == 2'b11);
        else
            f3_illegal = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        crosses    = ({1'b0, addr[1:0]} + size_bytes) > 3'd4;
        strb_wide  = {4'b0000, size_mask} << addr[1:0];
        wdata_wide = {32'h0, wdata} << {addr[1:0], 3'b000};
    end

    // Next-state logic; the response error code is chosen on the way into RESP
    always_comb begin
        state_d   = state_q;
        resp_err  = ERR_OK;
        beat      = (state_q == BEAT0) || (state_q == BEAT1);
        timed_out = beat && !mem.mem_ack && (cnt_q == TO_LAST);
        last_ack  = beat && mem.mem_ack && ((state_q == BEAT1) || !split_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (f3_illegal) begin
                        state_d  = RESP;
                        resp_err = ERR_ILLEGAL;
                    end else if (misaligned && !SPLIT_EN) begin
                        state_d  = RESP;
                        resp_err = ERR_MISALIGN;
                    end else begin
                        state_d = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (mem.mem_ack) begin
                    state_d = split_q ? BEAT1 : RESP;
                end else if (timed_out) begin
                    state_d  = RESP;
                    resp_err = ERR_TIMEOUT;
                end
            end
            BEAT1: begin
                if (mem.mem_ack) begin
                    state_d = RESP;
                end else if (timed_out) begin
                    state_d  = RESP;
                    resp_err = ERR_TIMEOUT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load extraction: shift the (possibly two-word) window down to the addressed byte, then extend
    always_comb begin
        load_pair = (state_q == BEAT1) ? {mem.mem_rdata, word0_q} : {32'h0, mem.mem_rdata};
        load_shr  = load_pair >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{load_shr[7]}}, load_shr[7:0]};
            3'b001:  load_ext = {{16{load_shr[15]}}, load_shr[15:0]};
            3'b100:  load_ext = {24'h0, load_shr[7:0]};
            3'b101:  load_ext = {16'h0, load_shr[15:0]};
            default: load_ext = load_shr[31:0];
        endcase
    end

    // State register; the asynchronous reset aborts any beat in flight without a done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Request latch, beat bus registers, per-beat timeout counter and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_q          <= 3'b000;
            off_q         <= 2'b00;
            split_q       <= 1'b0;
            strb_hi_q     <= 4'b0000;
            wdata_hi_q    <= 32'h0;
            word0_q       <= 32'h0;
            cnt_q         <= 8'h0;
            err           <= ERR_OK;
            rdata         <= 32'h0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wstrb <= 4'b0000;
            mem.mem_wdata <= 32'h0;
        end else begin
            if ((state_q == IDLE) && start) begin
                f3_q    <= funct3;
                off_q   <= addr[1:0];
                split_q <= SPLIT_EN && crosses;
                if (state_d == BEAT0) begin
                    mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                    mem.mem_we    <= is_store;
                    mem.mem_wstrb <= is_store ? strb_wide[3:0] : 4'b0000;
                    mem.mem_wdata <= is_store ? wdata_wide[31:0] : 32'h0;
                    strb_hi_q     <= is_store ? strb_wide[7:4] : 4'b0000;
                    wdata_hi_q    <= is_store ? wdata_wide[63:32] : 32'h0;
                end
            end
            if ((state_d != state_q) && ((state_d == BEAT0) || (state_d == BEAT1)))
                cnt_q <= 8'h0;
            else if (beat)
                cnt_q <= cnt_q + 8'd1;
            if ((state_q == BEAT0) && mem.mem_ack) begin
                word0_q <= mem.mem_rdata;
                if (split_q) begin
                    mem.mem_addr  <= mem.mem_addr + ADDR_W'(4);
                    mem.mem_wstrb <= strb_hi_q;
                    mem.mem_wdata <= wdata_hi_q;
                end
            end
            if ((state_d == RESP) && (state_q != RESP))
                err <= resp_err;
            if (last_ack && !mem.mem_we)
                rdata <= load_ext;
        end
    end

    assign mem.mem_req = (state_q == BEAT0) || (state_q == BEAT1);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == RESP);

endmodule

// File: tb/tb_lsu_multicycle.sv
// tb/tb_lsu_multicycle.sv - randomized self-checking bench for lsu_multicycle against a byte-level memory model
module tb_lsu_multicycle;
    localparam int ADDR_W = 32;
    localparam int TO     = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done;
    logic [1:0]  err;
    logic [31:0] rdata;

    lsu_multicycle_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_multicycle #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_store (is_store),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Device-side word memory and reference byte memory; untouched locations follow a fixed pattern
    logic [31:0] wmem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] exp_rdata = 32'h0;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5A;
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] a);
        logic [31:0] w;
        if (wmem.exists(a)) return wmem[a];
        for (int i = 0; i < 4; i++) w[8*i +: 8] = init_byte(a + 32'(i));
        return w;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
        wmem[a] = w;
        for (int i = 0; i < 4; i++) ref_mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    // Memory responder: acks after ack_delay wait cycles, records each acknowledged beat
    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] d;
    } beat_t;

    beat_t beats[$];
    int    ack_delay = 0;
    bit    ack_never = 1'b0;
    int    req_cnt = 0;
    int    req_cycles = 0;

    always @(negedge clk) begin
        beat_t b;
        logic [31:0] w;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        if (reset || !bus.mem_req) begin
            req_cnt = 0;
        end else begin
            req_cycles++;
            if (!ack_never && req_cnt >= ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = dev_read(bus.mem_addr);
                if (bus.mem_we) begin
                    w = dev_read(bus.mem_addr);
                    for (int i = 0; i < 4; i++)
                        if (bus.mem_wstrb[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
                    wmem[bus.mem_addr] = w;
                end
                b.a = bus.mem_addr; b.we = bus.mem_we; b.strb = bus.mem_wstrb; b.d = bus.mem_wdata;
                beats.push_back(b);
                req_cnt = 0;
            end else begin
                req_cnt++;
            end
        end
    end

    // Reference model: outcome of one operation from the architectural rules, on a byte memory
    task automatic model_op(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input int d, output logic [1:0] e, output int lat, output int nb);
        int n, off;
        bit illegal, mis;
        logic [31:0] v;
        n       = 1 << f3[1:0];
        off     = int'(a[1:0]);
        illegal = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis     = (off % n) != 0;
        e = 2'b00; lat = 1; nb = 0;
        if (illegal) begin
            e = 2'b11;
`ifndef LSU_MISALIGN_SPLIT_EN
        end else if (mis) begin
            e = 2'b01;
`endif
        end else begin
            nb  = (off + n > 4) ? 2 : 1;
            lat = nb * (d + 1) + 1;
            if (st) begin
                for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + 32'(i));
                if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
                exp_rdata = v;
            end
        end
    endtask

    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [1:0] e, output logic [31:0] rd);
        beats.delete();
        req_cycles = 0;
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        lat = 0;
        while (lat < 200) begin
            lat++;
            if (done === 1'b1) break;
            @(negedge clk);
        end
        e  = err;
        rd = rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, rdata} !== 36'h0) begin
            errors++;
            $display("FAIL reset_ctrl got busy=%b done=%b err=%b rdata=%h want all zero", busy, done, err, rdata);
        end
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata} !== 70'h0) begin
            errors++;
            $display("FAIL reset_bus got req=%b we=%b addr=%h strb=%b wdata=%h want all zero",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata);
        end
        reset = 1'b0;
        exp_rdata = 32'h0;
    endtask

    task automatic test_load_basic();
        int lat, elat, nb; logic [1:0] e, ee; logic [31:0] rd;
        ack_delay = 0;
        poke_word(32'h100, 32'hDEADBEEF);
        model_op(1'b0, 3'b010, 32'h100, 32'h0, 0, ee, elat, nb);
        do_op(1'b0, 3'b010, 32'h100, 32'h0, lat, e, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
        checks++; if (e !== 2'b00) begin errors++; $display("FAIL lw_err got %b want 00", e); end
        checks++; @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_byte_extend();
        int lat, elat, nb; logic [1:0] e, ee; logic [31:0] rd;
        poke_word(32'h100, 32'h80FFFF7F);
        model_op(1'b0, 3'b000, 32'h103, 32'h0, 0, ee, elat, nb);
        do_op(1'b0, 3'b000, 32'h103, 32'h0, lat, e, rd);
        checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got %h want ffffff80", rd); end
        model_op(1'b0, 3'b100, 32'h103, 32'h0, 0, ee, elat, nb);
        do_op(1'b0, 3'b100, 32'h103, 32'h0, lat, e, rd);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got %h want 00000080", rd); end
    endtask

    task automatic test_store_lanes();
        int lat, elat, nb; logic [1:0] e, ee; logic [31:0] rd;
        model_op(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 0, ee, elat, nb);
        do_op(1'b1, 3'b001, 32'h202, 32'h0000ABCD, lat, e, rd);
        checks++;
        if (beats.size() !== 1) begin
            errors++; $display("FAIL sh_beats got %0d want 1", beats.size());
        end else if (beats[0].a !== 32'h200 || beats[0].strb !== 4'b1100 ||
                     beats[0].d !== 32'hABCD0000 || beats[0].we !== 1'b1) begin
            errors++;
            $display("FAIL sh_lanes got addr=%h strb=%b wdata=%h we=%b want 00000200 1100 abcd0000 1",
                     beats[0].a, beats[0].strb, beats[0].d, beats[0].we);
        end
        checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL sh_rdata_hold got %h want %h", rd, exp_rdata); end
    endtask

    task automatic test_timeout();
        int lat; logic [1:0] e; logic [31:0] rd;
        ack_never = 1'b1;
        do_op(1'b0, 3'b010, 32'h40, 32'h0, lat, e, rd);
        ack_never = 1'b0;
        checks++; if (lat !== TO + 1) begin errors++; $display("FAIL to_latency got %0d want %0d", lat, TO + 1); end
        checks++; if (e !== 2'b10) begin errors++; $display("FAIL to_err got %b want 10", e); end
        checks++; if (rd !== exp_rdata) begin errors++; $display("FAIL to_rdata got %h want %h", rd, exp_rdata); end
        checks++; if (req_cycles !== TO) begin errors++; $display("FAIL to_req_cycles got %0d want %0d", req_cycles, TO); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL to_req_drop got %b want 0", bus.mem_req); end
    endtask

    task automatic test_misaligned_store();
        int lat, elat, nb; logic [1:0] e, ee; logic [31:0] rd;
        model_op(1'b1, 3'b010, 32'h0FF, 32'h11223344, 0, ee, elat, nb);
        do_op(1'b1, 3'b010, 32'h0FF, 32'h11223344, lat, e, rd);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (e !== 2'b00 || lat !== 3) begin errors++; $display("FAIL sw_split got err=%b lat=%0d want 00 3", e, lat); end
        checks++;
        if (beats.size() !== 2) begin
            errors++; $display("FAIL sw_split_beats got %0d want 2", beats.size());
        end else if (beats[0].a !== 32'h0FC || beats[0].strb !== 4'b1000 || beats[0].d[31:24] !== 8'h44 ||
                     beats[1].a !== 32'h100 || beats[1].strb !== 4'b0111 || beats[1].d[23:0] !== 24'h112233) begin
            errors++;
            $display("FAIL sw_split_lanes got %h/%b/%h %h/%b/%h want 000000fc/1000/44xxxxxx 00000100/0111/xx112233",
                     beats[0].a, beats[0].strb, beats[0].d, beats[1].a, beats[1].strb, beats[1].d);
        end
`else
        checks++; if (e !== 2'b01 || lat !== 1) begin errors++; $display("FAIL sw_misalign got err=%b lat=%0d want 01 1", e, lat); end
        checks++; if (req_cycles !== 0) begin errors++; $display("FAIL sw_misalign_req got %0d want 0", req_cycles); end
`endif
    endtask

    task automatic test_wrap_and_inword();
        int lat, elat, nb; logic [1:0] e, ee; logic [31:0] rd;
        poke_word(32'hFFFFFFFC, 32'hA1B2C3D4);
        poke_word(32'h00000000, 32'h55667788);
        model_op(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, ee, elat, nb);
        do_op(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, lat, e, rd);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (rd !== 32'h7788A1B2 || e !== 2'b00) begin errors++; $display("FAIL wrap_load got %h/%b want 7788a1b2/00", rd, e); end
        checks++;
        if (beats.size() !== 2 || beats[0].a !== 32'hFFFFFFFC || beats[beats.size()-1].a !== 32'h0) begin
            errors++; $display("FAIL wrap_addr got %0d beats first=%h want 2 beats fffffffc then 00000000", beats.size(), beats[0].a);
        end
`else
        checks++; if (e !== 2'b01 || rd !== exp_rdata) begin errors++; $display("FAIL wrap_misalign got %b/%h want 01/%h", e, rd, exp_rdata); end
`endif
        poke_word(32'h100, 32'h80FFFF7F);
        model_op(1'b0, 3'b001, 32'h101, 32'h0, 0, ee, elat, nb);
        do_op(1'b0, 3'b001, 32'h101, 32'h0, lat, e, rd);
        checks++;
        if (e !== ee || rd !== exp_rdata || lat !== elat) begin
            errors++; $display("FAIL lh_inword got %b/%h/%0d want %b/%h/%0d", e, rd, lat, ee, exp_rdata, elat);
        end
    endtask

    task automatic test_reset_mid_beat();
        bit saw_done;
        ack_never = 1'b1;
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h80;
        @(negedge clk);
        start = 1'b0;
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL abort_pre got req=%b want 1", bus.mem_req); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_async got req=%b busy=%b want 0 0", bus.mem_req, busy);
        end
        saw_done = 1'b0;
        repeat (3) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
        reset = 1'b0;
        ack_never = 1'b0;
        repeat (3) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1; end
        exp_rdata = 32'h0;
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got activity=%b want 0", saw_done); end
        checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL abort_rdata got %h want %h", rdata, exp_rdata); end
    endtask

    task automatic test_start_in_resp();
        int n, elat, nb; logic [1:0] ee;
        ack_delay = 0;
        model_op(1'b0, 3'b010, 32'h200, 32'h0, 0, ee, elat, nb);
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h200;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 50 && done !== 1'b1) begin @(negedge clk); n++; end
        start = 1'b1; is_store = 1'b0; funct3 = 3'b000; addr = 32'h300;
        @(negedge clk);
        start = 1'b0;
        checks++; if (n >= 50) begin errors++; $display("FAIL resp_done_timeout got no done want done"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL resp_start_ignored got busy=%b want 0", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rdata !== exp_rdata) begin
            errors++; $display("FAIL resp_start_idle got busy=%b rdata=%h want 0 %h", busy, rdata, exp_rdata);
        end
    endtask

    task automatic test_random(input int n_ops);
        int lat, elat, nb; logic [1:0] e, ee; logic [31:0] rd, a, wd; logic [2:0] f3; bit st;
        for (int k = 0; k < n_ops; k++) begin
            st = 1'($urandom);
            f3 = 3'($urandom);
            a  = 32'h1000 + 32'($urandom_range(0, 31));
            wd = $urandom;
            ack_delay = $urandom_range(0, 3);
            model_op(st, f3, a, wd, ack_delay, ee, elat, nb);
            do_op(st, f3, a, wd, lat, e, rd);
            checks++;
            if (e !== ee || lat !== elat || rd !== exp_rdata || beats.size() !== nb) begin
                errors++;
                $display("FAIL random op%0d st=%b f3=%b a=%h got err=%b lat=%0d rdata=%h beats=%0d want %b %0d %h %0d",
                         k, st, f3, a, e, lat, rd, beats.size(), ee, elat, exp_rdata, nb);
            end
        end
        ack_delay = 0;
    endtask

    task automatic test_memory_image();
        logic [31:0] want;
        for (logic [31:0] a = 32'h1000; a < 32'h1028; a += 32'd4) begin
            for (int i = 0; i < 4; i++) want[8*i +: 8] = ref_byte(a + 32'(i));
            checks++;
            if (dev_read(a) !== want) begin
                errors++; $display("FAIL mem_image addr=%h got %h want %h", a, dev_read(a), want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_byte_extend();
        test_store_lanes();
        test_timeout();
        test_misaligned_store();
        test_wrap_and_inword();
        test_reset_mid_beat();
        test_start_in_resp();
        test_random(300);
        test_memory_image();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
